// File: rtl/md_hazard_unit.sv
// Mul/div interlock: tracks remaining unit latency after each E-stage issue and holds D while a HI/LO user would arrive early.
// stall_d is combinational from the current inputs and count; all other outputs are registered, with a sticky overlap flag and a stall-cycle counter.
module md_hazard_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_start,
    input  logic             e_is_div,
    input  logic             d_md_op,
    input  logic             d_md_rd,
    input  logic             d_md_wr,
    input  logic             flush,
    output logic             stall_d,
    output logic             md_busy,
    output logic [CNT_W-1:0] cnt,
    output logic             err_overlap,
    output logic [31:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy_q, md_busy_d;
    logic             err_overlap_q, err_overlap_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic cnt_nz;
    logic d_use;

    always_comb begin
        cnt_nz  = (cnt_q != '0);
        d_use   = d_md_op | d_md_rd | d_md_wr;
        // An issue in flight this cycle blocks D even before the count is loaded.
        stall_d = d_use & (e_start | cnt_nz);
    end

    always_comb begin
        cnt_d         = cnt_q;
        err_overlap_d = err_overlap_q;
        if (flush) begin
            cnt_d = '0;
        end else if (e_start && !cnt_nz) begin
            cnt_d = e_is_div ? DIV_LOAD : MUL_LOAD;
        end else if (e_start) begin
            // The unit drops a request made while busy, so keep counting the original op.
            err_overlap_d = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
        end else if (cnt_nz) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        md_busy_d      = (cnt_d != '0);
        stall_cycles_d = stall_d ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            md_busy_q      <= 1'b0;
            err_overlap_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            cnt_q          <= cnt_d;
            md_busy_q      <= md_busy_d;
            err_overlap_q  <= err_overlap_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign cnt          = cnt_q;
    assign md_busy      = md_busy_q;
    assign err_overlap  = err_overlap_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_md_hazard_unit.sv
// Directed bench for md_hazard_unit: reset, mul/div stalls, overlap, flush, independent op, async reset mid-operation.
module tb_md_hazard_unit;

    logic        clk;
    logic        reset;
    logic        e_start;
    logic        e_is_div;
    logic        d_md_op;
    logic        d_md_rd;
    logic        d_md_wr;
    logic        flush;
    logic        stall_d;
    logic        md_busy;
    logic [3:0]  cnt;
    logic        err_overlap;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    md_hazard_unit #(
        .MUL_LAT(5),
        .DIV_LAT(10),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_start     (e_start),
        .e_is_div    (e_is_div),
        .d_md_op     (d_md_op),
        .d_md_rd     (d_md_rd),
        .d_md_wr     (d_md_wr),
        .flush       (flush),
        .stall_d     (stall_d),
        .md_busy     (md_busy),
        .cnt         (cnt),
        .err_overlap (err_overlap),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int bad;
        logic [3:0] mul_seq [6];
        mul_seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

        reset = 1'b1; e_start = 1'b1; e_is_div = 1'b0;
        d_md_op = 1'b0; d_md_rd = 1'b0; d_md_wr = 1'b0; flush = 1'b0;

        // Reset held with e_start asserted.
        tick(); tick(); tick();
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_err", 32'(err_overlap), 32'd0);
        chk("rst_stallcnt", stall_cycles, 32'd0);
        e_start = 1'b0; reset = 1'b0;
        #1;
        chk("rst_stall_d", 32'(stall_d), 32'd0);
        tick();

        // Multiply followed by MFLO held in D.
        e_start = 1'b1; e_is_div = 1'b0; d_md_rd = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (stall_d) n++;
            tick();
            e_start = 1'b0;
            chk($sformatf("mul_cnt%0d", i), 32'(cnt), 32'(mul_seq[i]));
        end
        #1;
        chk("mul_release", 32'(stall_d), 32'd0);
        chk("mul_nstall", 32'(n), 32'd6);
        chk("mul_stallcnt", stall_cycles, 32'd6);
        d_md_rd = 1'b0;
        tick();

        // Divide followed by MULT held in D.
        e_start = 1'b1; e_is_div = 1'b1; d_md_op = 1'b1;
        n = 0;
        #1;
        while (stall_d && n < 30) begin
            n++;
            tick();
            e_start = 1'b0;
            #1;
        end
        chk("div_nstall", 32'(n), 32'd11);
        chk("div_stallcnt", stall_cycles, 32'd17);
        chk("div_cnt_end", 32'(cnt), 32'd0);
        // Back-to-back issue in the cycle cnt reaches zero.
        d_md_op = 1'b0; e_start = 1'b1; e_is_div = 1'b0;
        tick();
        e_start = 1'b0;
        chk("reissue_cnt", 32'(cnt), 32'd5);
        chk("reissue_busy", 32'(md_busy), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("reissue_done", 32'(cnt), 32'd0);

        // Overlapping issue while a divide is in flight.
        e_start = 1'b1; e_is_div = 1'b1;
        tick();
        e_start = 1'b0;
        chk("ovl_load", 32'(cnt), 32'd10);
        tick(); tick(); tick();
        chk("ovl_cnt7", 32'(cnt), 32'd7);
        chk("ovl_err_pre", 32'(err_overlap), 32'd0);
        e_start = 1'b1; e_is_div = 1'b0;
        tick();
        e_start = 1'b0;
        chk("ovl_err_set", 32'(err_overlap), 32'd1);
        chk("ovl_cnt6", 32'(cnt), 32'd6);
        tick();
        chk("ovl_cnt5", 32'(cnt), 32'd5);
        for (int i = 0; i < 5; i++) tick();
        chk("ovl_done", 32'(cnt), 32'd0);
        chk("ovl_err_sticky", 32'(err_overlap), 32'd1);

        // Flush together with a new issue at cnt = 8.
        e_start = 1'b1; e_is_div = 1'b1;
        tick();
        e_start = 1'b0;
        tick(); tick();
        chk("fl_cnt8", 32'(cnt), 32'd8);
        flush = 1'b1; e_start = 1'b1; e_is_div = 1'b0;
        tick();
        flush = 1'b0; e_start = 1'b0;
        chk("fl_cnt", 32'(cnt), 32'd0);
        chk("fl_busy", 32'(md_busy), 32'd0);
        chk("fl_err", 32'(err_overlap), 32'd1);
        chk("fl_stallcnt", stall_cycles, 32'd17);

        // Independent instruction stream: no stalls, busy for MUL_LAT cycles.
        e_start = 1'b1; e_is_div = 1'b0;
        #1;
        bad = stall_d ? 1 : 0;
        tick();
        e_start = 1'b0;
        n = 0;
        while (md_busy && n < 20) begin
            n++;
            if (stall_d) bad++;
            tick();
        end
        chk("ind_busy_cycles", 32'(n), 32'd5);
        chk("ind_stall_seen", 32'(bad), 32'd0);
        chk("ind_stallcnt", stall_cycles, 32'd17);

        // Asynchronous reset in the middle of a divide with a stalled reader.
        e_start = 1'b1; e_is_div = 1'b1; d_md_rd = 1'b1;
        tick();
        e_start = 1'b0;
        tick(); tick();
        #1;
        chk("arst_pre_stall", 32'(stall_d), 32'd1);
        chk("arst_pre_cnt", 32'(cnt), 32'd8);
        reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_busy", 32'(md_busy), 32'd0);
        chk("arst_stall_d", 32'(stall_d), 32'd0);
        chk("arst_err", 32'(err_overlap), 32'd0);
        chk("arst_stallcnt", stall_cycles, 32'd0);
        d_md_rd = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
